nibble_serial_add_seq: RTL
==========================

Name: nibble_serial_add_seq

Overview:
Multi-precision add sequencer that sits directly in front of the team's 4-bit ripple-carry adder. It feeds that adder one nibble pair per cycle and consumes its sum and carry-out. It chains the carry through a register, so wide operands are summed with a single 4-bit adder. Operands arrive on a valid/ready input; the wide sum and final carry leave on a valid/ready output.

Parameters:
NIBBLES, 4, number of 4-bit slices per operand (W = 4*NIBBLES); legal range 1..16.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operand transfer request.
in_ready  output  1  sequencer can accept operands.
op_a  input  W  addend A.
op_b  input  W  addend B.
op_cin  input  1  carry into nibble 0.
add_a  output  4  nibble of A presented to the 4-bit adder.
add_b  output  4  nibble of B presented to the 4-bit adder.
add_cin  output  1  carry presented to the 4-bit adder.
add_s  input  4  adder sum (combinational return).
add_cout  input  1  adder carry-out (combinational return).
out_valid  output  1  result available.
out_ready  input  1  consumer accepts result.
result  output  W  (A + B + cin) mod 2^W.
result_cout  output  1  carry out of the top nibble.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- Internal state: registers a_reg, b_reg (W bits), carry_reg (1 bit), idx (max(1, clog2(NIBBLES)) bits), state in {IDLE, RUN, DONE}.
- Reset (rst=1 at an edge): state=IDLE, idx=0, carry_reg=0, a_reg=b_reg=0, result=0, result_cout=0, out_valid=0.
- in_ready=1 iff state==IDLE and rst==0. in_ready is combinational from state and rst.
- IDLE:
  - add_a=0, add_b=0, add_cin=0.
  - On in_valid & in_ready, capture op_a, op_b into a_reg, b_reg; carry_reg<=op_cin; idx<=0; result<=0; go to RUN.
  - in_valid without in_ready has no effect.
- RUN:
  - add_a=a_reg[4*idx+:4], add_b=b_reg[4*idx+:4], add_cin=carry_reg, all combinational.
  - Each edge: result[4*idx+:4]<=add_s; carry_reg<=add_cout.
  - If idx==NIBBLES-1: result_cout<=add_cout, out_valid<=1, go to DONE. Otherwise idx<=idx+1.
- DONE:
  - add_* driven 0; result and result_cout held stable; in_ready=0.
  - On out_valid & out_ready: out_valid<=0, go to IDLE.
- Latency: the accept edge is E0. out_valid rises after edge E0+NIBBLES. With out_ready held high, the next accept occurs at the earliest at edge E0+NIBBLES+2. Throughput is one op per NIBBLES+2 cycles.
- Input stability: op_a/op_b/op_cin are sampled only at the accept edge. Changes while in RUN or DONE are ignored.
- Output handshake: while out_valid=1 and out_ready=0, result, result_cout and out_valid hold indefinitely.
- Carry chain: carry propagates only through carry_reg, never combinationally across nibbles. The module contains no adder of its own; all arithmetic comes from add_s/add_cout.
- NIBBLES=1: RUN lasts exactly one cycle; idx stays 0.
- Reset mid-operation (RUN or DONE): the operation is aborted with no output pulse. out_valid=0 and in_ready=1 on the cycle after the reset edge (if rst is deasserted).
- Simultaneous in_valid and rst: reset wins; operands are not captured.

Test Plan:
- NIBBLES=4: op_a=0xFFFF, op_b=0x0001, op_cin=0 -> after 4 RUN cycles, result=0x0000, result_cout=1. Monitor shows add_cin=1 for nibbles 1..3.
- NIBBLES=4: op_a=0x1234, op_b=0x4321, op_cin=1 -> result=0x5556, result_cout=0. out_valid rises exactly 4 edges after accept; add_a sequence 4,3,2,1.
- Backpressure: after the previous case, hold out_ready=0 for 5 cycles and pulse in_valid with op_a=0xAAAA -> result stays 0x5556, in_ready=0, new operand not captured. Release out_ready -> IDLE next cycle.
- Reset mid-RUN: accept 0x0F0F+0x00F1, assert rst after 2 RUN cycles -> out_valid never asserts, result=0, in_ready=1 the cycle after rst drops. A following op 0x0001+0x0001 yields 0x0002, cout=0.
- Back-to-back with out_ready=1 and in_valid=1 held: 0x8000+0x8000 cin=0, then 0x7FFF+0x0000 cin=1 -> results 0x0000/cout=1, then 0x8000/cout=0. Accepts spaced exactly 6 cycles apart.
- NIBBLES=1: op_a=0xF, op_b=0xF, op_cin=1 -> result=0xF, result_cout=1, out_valid one edge after accept.

Source files
------------

// File: rtl/nibble_serial_add_seq.sv
// Multi-precision add sequencer: drives an external 4-bit adder one nibble per cycle,
// chaining the carry through a register to build a W-bit sum.
`timescale 1ns/1ps
module nibble_serial_add_seq #(
  parameter int unsigned NIBBLES = 4,
  localparam int unsigned W = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         op_cin,
  output logic [3:0]   add_a,
  output logic [3:0]   add_b,
  output logic         add_cin,
  input  logic [3:0]   add_s,
  input  logic         add_cout,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         result_cout
);

  localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  a_reg, b_reg;
  logic          carry_reg;
  logic [IW-1:0] idx;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (idx == LAST) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Nibble select is an explicit mux so no unused shifted bits are left behind.
  always_comb begin
    in_ready = (state == IDLE) && !rst;
    add_a    = '0;
    add_b    = '0;
    add_cin  = 1'b0;
    if (state == RUN) begin
      add_cin = carry_reg;
      for (int unsigned i = 0; i < NIBBLES; i++) begin
        if (idx == i[IW-1:0]) begin
          add_a = a_reg[4*i +: 4];
          add_b = b_reg[4*i +: 4];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg       <= '0;
      b_reg       <= '0;
      carry_reg   <= 1'b0;
      idx         <= '0;
      result      <= '0;
      result_cout <= 1'b0;
      out_valid   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= op_a;
            b_reg     <= op_b;
            carry_reg <= op_cin;
            idx       <= '0;
            result    <= '0;
          end
        end
        RUN: begin
          for (int unsigned i = 0; i < NIBBLES; i++) begin
            if (idx == i[IW-1:0]) result[4*i +: 4] <= add_s;
          end
          carry_reg <= add_cout;
          if (idx == LAST) begin
            result_cout <= add_cout;
            out_valid   <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
